// File: rtl/vproc_xif_result_sink_if.sv
// Bundle of handshake and data signals between the host-core wrapper and the
// XIF result sink. The slave modport is the sink itself; the master modport is
// the surrounding core logic (issue stage, XIF result port, writeback arbiter).
// The sink's port names are kept in these signal names so that waveforms read
// directly against the block's port list.
interface vproc_xif_result_sink_if #(
    parameter int unsigned XIF_ID_W = 3
);
    // Offload tracking
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [XIF_ID_W-1:0] issue_id_i;
    logic                issue_wb_i;

    // XIF result channel
    logic                result_valid_i;
    logic                result_ready_o;
    logic [XIF_ID_W-1:0] result_id_i;
    logic [31:0]         result_data_i;
    logic [4:0]          result_rd_i;
    logic                result_we_i;
    logic                result_exc_i;
    logic [5:0]          result_exccode_i;

    // Register-file write port
    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [4:0]          wb_addr_o;
    logic [31:0]         wb_data_o;

    // Exception report and status
    logic                exc_valid_o;
    logic [XIF_ID_W-1:0] exc_id_o;
    logic [5:0]          exc_code_o;
    logic [XIF_ID_W:0]   outstanding_o;
    logic                protocol_err_o;

    modport slave (
        input  issue_valid_i, issue_id_i, issue_wb_i,
        input  result_valid_i, result_id_i, result_data_i, result_rd_i,
        input  result_we_i, result_exc_i, result_exccode_i,
        input  wb_ready_i,
        output issue_ready_o, result_ready_o,
        output wb_valid_o, wb_addr_o, wb_data_o,
        output exc_valid_o, exc_id_o, exc_code_o,
        output outstanding_o, protocol_err_o
    );

    modport master (
        output issue_valid_i, issue_id_i, issue_wb_i,
        output result_valid_i, result_id_i, result_data_i, result_rd_i,
        output result_we_i, result_exc_i, result_exccode_i,
        output wb_ready_i,
        input  issue_ready_o, result_ready_o,
        input  wb_valid_o, wb_addr_o, wb_data_o,
        input  exc_valid_o, exc_id_o, exc_code_o,
        input  outstanding_o, protocol_err_o
    );
endinterface

// File: rtl/vproc_xif_result_sink.sv
// Core-side receiver for the XIF result channel of the vector coprocessor.
// Offloaded instructions are tracked as a window [head_q, head_q + cnt_q) of
// consecutive XIF IDs. Results are accepted strictly in issue order, x-register
// writes are staged in a one-entry writeback register toward the integer
// regfile, and a result carrying an exception turns into a one-cycle report
// plus a flush of every younger in-flight instruction.
//
// Optional build macro: VPROC_RESULT_CHECK_EN
//   defined   - out-of-order or unexpected results are drained and raise the
//               sticky protocol_err_o flag, as do writes from instructions that
//               were issued without an x-register destination.
//   undefined - protocol_err_o is tied low and mismatching results stall.
module vproc_xif_result_sink #(
    parameter int unsigned XIF_ID_W       = 3,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input logic                    clk_i,
    input logic                    sync_rst_i,
    vproc_xif_result_sink_if.slave xif
);

    localparam int unsigned         DEPTH   = 1 << XIF_ID_W;
    localparam logic [XIF_ID_W:0]   CNT_MAX = (XIF_ID_W + 1)'(DEPTH);
    localparam logic [XIF_ID_W:0]   CNT_ONE = (XIF_ID_W + 1)'(1);
    localparam logic [XIF_ID_W-1:0] ID_ONE  = XIF_ID_W'(1);

    // In-flight window and per-ID writeback expectation
    logic [XIF_ID_W-1:0] head_q;
    logic [XIF_ID_W:0]   cnt_q;
    logic [DEPTH-1:0]    wb_en_q;

    // One-entry writeback staging register
    logic                wb_valid_q;
    logic [4:0]          wb_addr_q;
    logic [31:0]         wb_data_q;

    // Registered exception report
    logic                exc_valid_q;
    logic [XIF_ID_W-1:0] exc_id_q;
    logic [5:0]          exc_code_q;

    // Handshake decode
    logic empty;
    logic full;
    logic id_match;
    logic wb_free;
    logic issue_fire;
    logic result_fire;
    logic exc_fire;
    logic wb_load;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_MAX);
    assign id_match = (xif.result_id_i == head_q);

    // The staging register can take a new entry when it is empty or when the
    // current entry leaves this very cycle.
    assign wb_free = ~wb_valid_q | xif.wb_ready_i;

    // A result is consumed only if it is the oldest in-flight instruction and
    // its writeback has somewhere to go. Issue never gates result acceptance,
    // and a retire in the same cycle never makes room for an issue.
    assign result_fire = xif.result_valid_i & ~empty & id_match & wb_free;
    assign issue_fire  = xif.issue_valid_i & ~full;
    assign exc_fire    = result_fire & xif.result_exc_i;

    // Excepting results never write, and x0 writes are silently dropped.
    assign wb_load = result_fire & xif.result_we_i & ~xif.result_exc_i
                     & (xif.result_rd_i != 5'd0);

    assign xif.issue_ready_o = ~full;
    assign xif.outstanding_o = cnt_q;

`ifdef VPROC_RESULT_CHECK_EN
    logic mismatch;
    logic wb_unexpected;
    logic prot_err_q;

    // Anything presented while nothing is in flight, or not carrying the
    // head ID, is a protocol violation; it is swallowed so the channel keeps
    // moving, but it must not disturb the tracking state.
    assign mismatch      = xif.result_valid_i & (empty | ~id_match);
    assign wb_unexpected = result_fire & xif.result_we_i & ~wb_en_q[head_q];

    assign xif.result_ready_o = result_fire | mismatch;
    assign xif.protocol_err_o = prot_err_q;

    // Sticky violation flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            prot_err_q <= 1'b0;
        end else if (mismatch | wb_unexpected) begin
            prot_err_q <= 1'b1;
        end
    end
`else
    // The writeback-expected bits are only consulted by the protocol checker.
    logic unused_wb_en;
    assign unused_wb_en = ^wb_en_q;

    assign xif.result_ready_o = result_fire;
    assign xif.protocol_err_o = 1'b0;
`endif

    // Track the oldest in-flight ID and the number of in-flight instructions;
    // an exception flushes the window but keeps an issue from the same cycle.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            head_q <= '0;
            cnt_q  <= '0;
        end else if (exc_fire) begin
            if (issue_fire) begin
                head_q <= xif.issue_id_i;
                cnt_q  <= CNT_ONE;
            end else begin
                head_q <= xif.result_id_i + ID_ONE;
                cnt_q  <= '0;
            end
        end else begin
            if (result_fire) begin
                head_q <= head_q + ID_ONE;
            end
            if (issue_fire && !result_fire) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (result_fire && !issue_fire) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    // Remember, per ID, whether the issued instruction targets an x-register
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            wb_en_q <= '0;
        end else if (issue_fire) begin
            wb_en_q[xif.issue_id_i] <= xif.issue_wb_i;
        end
    end

    // Writeback valid holds until the arbiter takes it; a reset drops it
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            wb_valid_q <= 1'b0;
        end else if (wb_load) begin
            wb_valid_q <= 1'b1;
        end else if (xif.wb_ready_i) begin
            wb_valid_q <= 1'b0;
        end
    end

    // Writeback payload only changes on a load, so it is stable while stalled
    always_ff @(posedge clk_i) begin
        if (wb_load) begin
            wb_addr_q <= xif.result_rd_i;
            wb_data_q <= xif.result_data_i;
        end
    end

    // Exception report is a single-cycle pulse following the accept
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            exc_valid_q <= 1'b0;
        end else begin
            exc_valid_q <= exc_fire;
        end
    end

    // Capture the faulting ID and cause alongside the pulse
    always_ff @(posedge clk_i) begin
        if (exc_fire) begin
            exc_id_q   <= xif.result_id_i;
            exc_code_q <= xif.result_exccode_i;
        end
    end

    // Payload outputs are forced to zero while invalid when requested, which
    // keeps downstream X-propagation out of the regfile mux and trap logic.
    assign xif.wb_valid_o  = wb_valid_q;
    assign xif.wb_addr_o   = (DONT_CARE_ZERO && !wb_valid_q) ? 5'd0  : wb_addr_q;
    assign xif.wb_data_o   = (DONT_CARE_ZERO && !wb_valid_q) ? 32'd0 : wb_data_q;

    assign xif.exc_valid_o = exc_valid_q;
    assign xif.exc_id_o    = (DONT_CARE_ZERO && !exc_valid_q) ? '0   : exc_id_q;
    assign xif.exc_code_o  = (DONT_CARE_ZERO && !exc_valid_q) ? 6'd0 : exc_code_q;

endmodule
